// File: rtl/reg_file_scan_pkg.sv
// Shared definitions for the scanned register file: default geometry and the
// scan engine state encoding used by the top level.
package reg_file_scan_pkg;

    // Default geometry of the register store
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_AW    = 5;

    // Scan engine state encoding, kept as plain constants so older tools and
    // waveform decoders see stable numeric values
    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE = 2'd0;
    localparam scan_state_t ST_LOAD = 2'd1;
    localparam scan_state_t ST_SEND = 2'd2;

endpackage

// File: rtl/reg_file_scan_if.sv
// Bus bundle for the scanned register file: write port, two read ports and
// the valid/ready scan-out stream. The master side drives requests, the slave
// side is the register file itself.
interface reg_file_scan_if
    import reg_file_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
);

    // Write port
    logic             W;
    logic [AW-1:0]    WN;
    logic [WIDTH-1:0] WD;

    // Read ports
    logic [AW-1:0]    RN1;
    logic [AW-1:0]    RN2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;

    // Scan-out stream
    logic             scan_go;
    logic             scan_vld;
    logic             scan_rdy;
    logic [AW-1:0]    scan_idx;
    logic [WIDTH-1:0] scan_dat;
    logic             scan_busy;

    modport master (
        output W, WN, WD, RN1, RN2, scan_go, scan_rdy,
        input  RD1, RD2, scan_vld, scan_idx, scan_dat, scan_busy
    );

    modport slave (
        input  W, WN, WD, RN1, RN2, scan_go, scan_rdy,
        output RD1, RD2, scan_vld, scan_idx, scan_dat, scan_busy
    );

endinterface

// File: rtl/reg_file_scan_core.sv
// Storage array of the register file: one write port, three combinational
// read ports (two datapath operands plus one for the scan engine), entry 0
// hardwired to zero and write-through bypass on every read port.
module reg_file_core
    import reg_file_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wn,
    input  logic [WIDTH-1:0] i_wd,
    input  logic [AW-1:0]    i_rn1,
    input  logic [AW-1:0]    i_rn2,
    input  logic [AW-1:0]    i_rn3,
    output logic [WIDTH-1:0] o_rd1,
    output logic [WIDTH-1:0] o_rd2,
    output logic [WIDTH-1:0] o_rd3
);

    // Entry 0 is never written, so it stays at its reset value of zero
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [WIDTH-1:0] w_rd3;

    // Array update: writes to entry 0 are dropped, reset clears every entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wn != '0)) begin
            r_mem[i_wn] <= i_wd;
        end
    end

    // Read muxes: stored value, overridden by a same-cycle write, and forced
    // to zero for register 0 regardless of any write aimed at it
    always_comb begin
        w_rd1 = r_mem[i_rn1];
        if (i_we && (i_wn == i_rn1)) begin
            w_rd1 = i_wd;
        end
        if (i_rn1 == '0) begin
            w_rd1 = '0;
        end

        w_rd2 = r_mem[i_rn2];
        if (i_we && (i_wn == i_rn2)) begin
            w_rd2 = i_wd;
        end
        if (i_rn2 == '0) begin
            w_rd2 = '0;
        end

        w_rd3 = r_mem[i_rn3];
        if (i_we && (i_wn == i_rn3)) begin
            w_rd3 = i_wd;
        end
        if (i_rn3 == '0) begin
            w_rd3 = '0;
        end
    end

    assign o_rd1 = w_rd1;
    assign o_rd2 = w_rd2;
    assign o_rd3 = w_rd3;

endmodule

// File: rtl/reg_file_scan.sv
// Register file with debug scan-out. The core provides storage and operand
// reads; this wrapper adds a three-state engine that snapshots each entry in
// turn and streams it over a valid/ready handshake.
module reg_file_scan
    import reg_file_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic           clk,
    input  logic           reset,
    reg_file_scan_if.slave bus
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    scan_state_t      r_state;
    logic [AW-1:0]    r_idx;
    logic             r_vld;
    logic [AW-1:0]    r_sidx;
    logic [WIDTH-1:0] r_sdat;
    logic             r_busy;

    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [WIDTH-1:0] w_scan_rd;

    reg_file_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .i_clk (clk),
        .i_rst (reset),
        .i_we  (bus.W),
        .i_wn  (bus.WN),
        .i_wd  (bus.WD),
        .i_rn1 (bus.RN1),
        .i_rn2 (bus.RN2),
        .i_rn3 (r_idx),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .o_rd3 (w_scan_rd)
    );

    // Scan engine: LOAD captures one entry (with bypass) into the output
    // holding register, SEND holds it until accepted, then moves on or stops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_sidx  <= '0;
            r_sdat  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.scan_go) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_sdat  <= w_scan_rd;
                    r_sidx  <= r_idx;
                    r_vld   <= 1'b1;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (r_vld && bus.scan_rdy) begin
                        r_vld <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.RD1       = w_rd1;
    assign bus.RD2       = w_rd2;
    assign bus.scan_vld  = r_vld;
    assign bus.scan_idx  = r_sidx;
    assign bus.scan_dat  = r_sdat;
    assign bus.scan_busy = r_busy;

endmodule
